// File: rtl/wb_sram_arbiter_if.sv
// Wishbone classic bus bundle used for both arbiter master ports and the
// SRAM-side slave port.
//
// Handshake: a transfer is requested while cyc and stb are both high; the
// slave completes it by raising ack for one cycle, and read data on dat_r is
// valid only in that ack cycle. The master may change address/data or drop
// stb/cyc once it has seen ack.
interface wb_sram_arbiter_if #(
    parameter int AWIDTH = 20
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [3:0]        sel;
    logic [AWIDTH-1:0] addr;
    logic [31:0]       dat_w;
    logic [31:0]       dat_r;
    logic              ack;

    // Side that starts transfers (bus master).
    modport master (
        output cyc, stb, we, sel, addr, dat_w,
        input  dat_r, ack
    );

    // Side that answers transfers (bus slave).
    modport slave (
        input  cyc, stb, we, sel, addr, dat_w,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_sram_arbiter.sv
// Two-master Wishbone arbiter in front of a single SRAM slave.
// Master 0 is the CPU, master 1 the DMA/video engine. A master keeps the bus
// for as long as it holds cyc; every ownership change passes through IDLE so
// the slave always sees at least one strobe-low cycle between owners.
module wb_sram_arbiter #(
    parameter int AWIDTH     = 20,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_sram_arbiter_if.slave      m0_bus,
    wb_sram_arbiter_if.slave      m1_bus,
    wb_sram_arbiter_if.master     s_bus,
    output logic [1:0]            gnt_o,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic              w_last_next;

    logic              w_req0;
    logic              w_req1;

    logic              w_s_cyc;
    logic              w_s_stb;
    logic              w_s_we;
    logic [3:0]        w_s_sel;
    logic [AWIDTH-1:0] w_s_addr;
    logic [31:0]       w_s_dat;
    logic              w_m0_ack;
    logic              w_m1_ack;
    logic [1:0]        w_gnt;

    assign w_req0 = m0_bus.cyc & m0_bus.stb;
    assign w_req1 = m1_bus.cyc & m1_bus.stb;

    // State and last-winner registers; reset leaves last=1 so m0 wins the first tie.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_next;
        end
    end

    // Next-state: arbitrate only from IDLE, hold the grant while the owner keeps cyc.
    always_comb begin
        w_next      = r_state;
        w_last_next = r_last;
        case (r_state)
            ST_IDLE: begin
                // m0 wins if alone, under fixed priority, or when m1 won last time.
                if (w_req0 && (!w_req1 || FIXED_PRIO || r_last)) begin
                    w_next      = ST_GNT0;
                    w_last_next = 1'b0;
                end else if (w_req1) begin
                    w_next      = ST_GNT1;
                    w_last_next = 1'b1;
                end
            end
            ST_GNT0: begin
                if (!m0_bus.cyc) begin
                    w_next = ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!m1_bus.cyc) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output mux: route the owner to the slave, steer ack back; everything quiet in IDLE or reset.
    always_comb begin
        w_s_cyc  = 1'b0;
        w_s_stb  = 1'b0;
        w_s_we   = 1'b0;
        w_s_sel  = 4'b0000;
        w_s_addr = '0;
        w_s_dat  = 32'd0;
        w_m0_ack = 1'b0;
        w_m1_ack = 1'b0;
        w_gnt    = 2'b00;
        if (!wb_rst_i) begin
            case (r_state)
                ST_GNT0: begin
                    w_s_cyc  = m0_bus.cyc;
                    w_s_stb  = m0_bus.stb;
                    w_s_we   = m0_bus.we;
                    w_s_sel  = m0_bus.sel;
                    w_s_addr = m0_bus.addr;
                    w_s_dat  = m0_bus.dat_w;
                    w_m0_ack = s_bus.ack & m0_bus.stb;
                    w_gnt    = 2'b01;
                end
                ST_GNT1: begin
                    w_s_cyc  = m1_bus.cyc;
                    w_s_stb  = m1_bus.stb;
                    w_s_we   = m1_bus.we;
                    w_s_sel  = m1_bus.sel;
                    w_s_addr = m1_bus.addr;
                    w_s_dat  = m1_bus.dat_w;
                    w_m1_ack = s_bus.ack & m1_bus.stb;
                    w_gnt    = 2'b10;
                end
                default: begin
                    // IDLE: a stray slave ack reaches nobody.
                end
            endcase
        end
    end

    assign s_bus.cyc    = w_s_cyc;
    assign s_bus.stb    = w_s_stb;
    assign s_bus.we     = w_s_we;
    assign s_bus.sel    = w_s_sel;
    assign s_bus.addr   = w_s_addr;
    assign s_bus.dat_w  = w_s_dat;

    // Read data is broadcast; each master qualifies it with its own ack.
    assign m0_bus.dat_r = s_bus.dat_r;
    assign m1_bus.dat_r = s_bus.dat_r;
    assign m0_bus.ack   = w_m0_ack;
    assign m1_bus.ack   = w_m1_ack;

    assign gnt_o        = w_gnt;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Bench for wb_sram_arbiter: a round-robin instance with a 1-wait-state SRAM
// model, plus a fixed-priority instance driven for grant-order checks.
`timescale 1ns/1ps
module tb_wb_sram_arbiter;

    localparam int AW = 20;

    typedef struct packed {
        logic        we;
        logic [31:0] dat;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- buses and DUTs ----------------
    wb_sram_arbiter_if #(.AWIDTH(AW)) m0_bus ();
    wb_sram_arbiter_if #(.AWIDTH(AW)) m1_bus ();
    wb_sram_arbiter_if #(.AWIDTH(AW)) s_bus ();
    wb_sram_arbiter_if #(.AWIDTH(AW)) fm0_bus ();
    wb_sram_arbiter_if #(.AWIDTH(AW)) fm1_bus ();
    wb_sram_arbiter_if #(.AWIDTH(AW)) fs_bus ();

    logic [1:0] gnt;
    logic [1:0] dbg_state;
    logic [1:0] f_gnt;
    logic [1:0] f_dbg_state;

    wb_sram_arbiter #(.AWIDTH(AW), .FIXED_PRIO(1'b0)) u_dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .m0_bus      (m0_bus),
        .m1_bus      (m1_bus),
        .s_bus       (s_bus),
        .gnt_o       (gnt),
        .dbg_state_o (dbg_state)
    );

    wb_sram_arbiter #(.AWIDTH(AW), .FIXED_PRIO(1'b1)) u_dut_fp (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .m0_bus      (fm0_bus),
        .m1_bus      (fm1_bus),
        .s_bus       (fs_bus),
        .gnt_o       (f_gnt),
        .dbg_state_o (f_dbg_state)
    );

    assign fs_bus.ack   = 1'b0;
    assign fs_bus.dat_r = 32'd0;

    // ---------------- SRAM slave model (one wait state) ----------------
    logic        slv_en;
    logic        inject_ack;
    logic        r_ack;
    logic [31:0] mem [16];

    always @(posedge clk) begin
        if (rst) begin
            r_ack <= 1'b0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            mem[4] <= 32'hDEAD_BEEF;
        end else begin
            r_ack <= s_bus.cyc & s_bus.stb & ~r_ack;
            if (s_bus.cyc && s_bus.stb && s_bus.we && !r_ack) begin
                for (int b = 0; b < 4; b++)
                    if (s_bus.sel[b]) mem[s_bus.addr[5:2]][8*b +: 8] <= s_bus.dat_w[8*b +: 8];
            end
        end
    end

    assign s_bus.ack   = (slv_en & r_ack) | inject_ack;
    assign s_bus.dat_r = mem[s_bus.addr[5:2]];

    // ---------------- scoreboard ----------------
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every master ack pops that master's expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m0_bus.ack === 1'b1) begin
                if (exp_q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m0_unexpected_ack actual=ack expected=no_ack t=%0t", $time);
                end else begin
                    e = exp_q0.pop_front();
                    if (!e.we) check("m0_rdata", m0_bus.dat_r, e.dat);
                end
            end
            if (m1_bus.ack === 1'b1) begin
                if (exp_q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m1_unexpected_ack actual=ack expected=no_ack t=%0t", $time);
                end else begin
                    e = exp_q1.pop_front();
                    if (!e.we) check("m1_rdata", m1_bus.dat_r, e.dat);
                end
            end
        end
    end

    // Owner-change gap watcher: strobe-low cycles between m1 releasing and m0 taking over.
    logic gap_en = 1'b0;
    logic gap_seen_m1 = 1'b0;
    logic gap_done = 1'b0;
    int   stb_low = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (gap_en) begin
                if (gnt == 2'b10) begin
                    gap_seen_m1 = 1'b1;
                    stb_low     = 0;
                end else if (gap_seen_m1 && !gap_done) begin
                    if (s_bus.stb == 1'b0) stb_low++;
                    if (gnt == 2'b01) begin
                        check("owner_gap_stb_low_cycles", 32'(stb_low), 32'd1);
                        gap_done = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int id, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] addr, input logic [31:0] dat, input logic [3:0] sel);
        if (id == 0) begin
            m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
            m0_bus.addr = addr; m0_bus.dat_w = dat; m0_bus.sel = sel;
        end else begin
            m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
            m1_bus.addr = addr; m1_bus.dat_w = dat; m1_bus.sel = sel;
        end
    endtask

    task automatic set_f(input int id, input logic req);
        if (id == 0) begin
            fm0_bus.cyc = req; fm0_bus.stb = req;
        end else begin
            fm1_bus.cyc = req; fm1_bus.stb = req;
        end
    endtask

    // Waits for this master's ack (bounded), returns #1 after the sampling negedge.
    task automatic wait_ack(input int id);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (((id == 0) ? m0_bus.ack : m1_bus.ack) === 1'b1) got = 1'b1;
        end
        #1;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout_m%0d actual=no_ack expected=ack", id);
        end
    endtask

    // Single transfer; cyc drops in the ack cycle.
    task automatic xfer(input int id, input logic we, input logic [AW-1:0] addr,
                        input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] exp_rd);
        exp_t e;
        e.we = we;
        e.dat = exp_rd;
        if (id == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        set_m(id, 1'b1, 1'b1, we, addr, dat, sel);
        wait_ack(id);
        set_m(id, 1'b0, 1'b0, 1'b0, '0, 32'd0, 4'b0000);
    endtask

    // m1 burst of four writes with cyc and stb held between beats.
    task automatic m1_block();
        exp_t e;
        e.we = 1'b1;
        e.dat = 32'd0;
        for (int k = 0; k < 4; k++) exp_q1.push_back(e);
        for (int k = 0; k < 4; k++) begin
            set_m(1, 1'b1, 1'b1, 1'b1, AW'(32'h20 + 4 * k), 32'h1111_0001 + 32'(k), 4'hF);
            wait_ack(1);
        end
        set_m(1, 1'b0, 1'b0, 1'b0, '0, 32'd0, 4'b0000);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        slv_en = 1'b0;
        inject_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, 32'd0, 4'b0000);
        set_m(1, 1'b0, 1'b0, 1'b0, '0, 32'd0, 4'b0000);
        fm0_bus.we = 1'b0; fm0_bus.sel = 4'h0; fm0_bus.addr = '0; fm0_bus.dat_w = 32'd0;
        fm1_bus.we = 1'b0; fm1_bus.sel = 4'h0; fm1_bus.addr = '0; fm1_bus.dat_w = 32'd0;
        set_f(0, 1'b0);
        set_f(1, 1'b0);

        // Reset: outputs quiet even with a request and a stray ack present.
        step();
        set_m(0, 1'b1, 1'b1, 1'b0, AW'(32'h10), 32'd0, 4'hF);
        inject_ack = 1'b1;
        step();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_s_cyc", 32'(s_bus.cyc), 32'd0);
        check("rst_s_stb", 32'(s_bus.stb), 32'd0);
        check("rst_s_sel", 32'(s_bus.sel), 32'd0);
        check("rst_m0_ack", 32'(m0_bus.ack), 32'd0);
        check("rst_m1_ack", 32'(m1_bus.ack), 32'd0);
        inject_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, 32'd0, 4'b0000);
        rst = 1'b0;
        check("post_rst_gnt", 32'(gnt), 32'd0);
        check("post_rst_s_stb", 32'(s_bus.stb), 32'd0);
        check("post_rst_state", 32'(dbg_state), 32'd0);
        check("post_rst_fp_gnt", 32'(f_gnt), 32'd0);

        // Tie-breaks: round-robin alternates, fixed priority keeps m0.
        set_m(0, 1'b1, 1'b1, 1'b0, AW'(32'h4), 32'd0, 4'hF);
        set_m(1, 1'b1, 1'b1, 1'b0, AW'(32'h8), 32'd0, 4'hF);
        set_f(0, 1'b1); set_f(1, 1'b1);
        step();
        check("rr_c1_gnt", 32'(gnt), 32'h1);
        check("fp_c1_gnt", 32'(f_gnt), 32'h1);
        check("rr_c1_m1_ack", 32'(m1_bus.ack), 32'd0);
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        set_f(0, 1'b0);
        step();
        check("rr_c2_gnt", 32'(gnt), 32'h0);
        check("rr_c2_s_stb", 32'(s_bus.stb), 32'd0);
        check("fp_c2_gnt", 32'(f_gnt), 32'h0);
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
        set_f(0, 1'b1);
        step();
        check("rr_c3_gnt", 32'(gnt), 32'h2);
        check("fp_c3_gnt", 32'(f_gnt), 32'h1);
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        set_f(0, 1'b0);
        step();
        check("rr_c4_gnt", 32'(gnt), 32'h0);
        check("rr_c4_s_stb", 32'(s_bus.stb), 32'd0);
        check("fp_c4_gnt", 32'(f_gnt), 32'h0);
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
        step();
        check("rr_c5_gnt", 32'(gnt), 32'h1);
        check("fp_c5_gnt", 32'(f_gnt), 32'h2);
        set_m(0, 1'b0, 1'b0, 1'b0, '0, 32'd0, 4'b0000);
        set_m(1, 1'b0, 1'b0, 1'b0, '0, 32'd0, 4'b0000);
        set_f(1, 1'b0);
        step();
        step();
        check("idle_after_rr_gnt", 32'(gnt), 32'h0);

        // Single m0 read: grant at N+1, ack with data at N+2, release next edge.
        slv_en = 1'b1;
        exp_q0.push_back('{we: 1'b0, dat: 32'hDEAD_BEEF});
        set_m(0, 1'b1, 1'b1, 1'b0, AW'(32'h10), 32'd0, 4'hF);
        step();
        check("rd_n1_gnt", 32'(gnt), 32'h1);
        check("rd_n1_s_stb", 32'(s_bus.stb), 32'd1);
        check("rd_n1_s_addr", 32'(s_bus.addr), 32'h10);
        check("rd_n1_s_we", 32'(s_bus.we), 32'd0);
        check("rd_n1_m0_ack", 32'(m0_bus.ack), 32'd0);
        step();
        check("rd_n2_m0_ack", 32'(m0_bus.ack), 32'd1);
        check("rd_n2_m0_dat", m0_bus.dat_r, 32'hDEAD_BEEF);
        check("rd_n2_m1_ack", 32'(m1_bus.ack), 32'd0);
        @(negedge clk);
        #1;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, 32'd0, 4'b0000);
        step();
        check("rd_release_gnt", 32'(gnt), 32'h0);

        // Stray slave ack while IDLE, even with a fresh request on m0.
        slv_en = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, AW'(32'h14), 32'd0, 4'hF);
        inject_ack = 1'b1;
        #1;
        check("idle_ack_m0", 32'(m0_bus.ack), 32'd0);
        check("idle_ack_m1", 32'(m1_bus.ack), 32'd0);
        @(negedge clk);
        #1;
        inject_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, 32'd0, 4'b0000);
        step();
        step();
        slv_en = 1'b1;

        // m1 burst holds the bus; m0 waits, then reads back m1's last word.
        gap_en = 1'b1;
        fork
            m1_block();
            begin
                step();
                xfer(0, 1'b0, AW'(32'h2C), 32'd0, 4'hF, 32'h1111_0004);
            end
        join
        gap_en = 1'b0;
        check("owner_gap_observed", 32'(gap_done), 32'd1);
        step();

        // Byte-lane write by m0, read back by m1; then concurrent reads.
        xfer(0, 1'b1, AW'(32'h30), 32'h5555_6666, 4'b0011, 32'd0);
        step();
        xfer(1, 1'b0, AW'(32'h30), 32'd0, 4'hF, 32'hA000_6666);
        step();
        fork
            xfer(0, 1'b0, AW'(32'h04), 32'd0, 4'hF, 32'hA000_0001);
            xfer(1, 1'b0, AW'(32'h08), 32'd0, 4'hF, 32'hA000_0002);
        join
        step();
        step();

        // Reset during GNT1 with stb high and the slave ack pending.
        set_m(1, 1'b1, 1'b1, 1'b0, AW'(32'h0C), 32'd0, 4'hF);
        step();
        check("rst_mid_gnt1", 32'(gnt), 32'h2);
        check("rst_mid_s_stb", 32'(s_bus.stb), 32'd1);
        step();
        rst = 1'b1;
        #1;
        check("rst_mid_ack_blocked", 32'(m1_bus.ack), 32'd0);
        check("rst_mid_gnt_quiet", 32'(gnt), 32'h0);
        check("rst_mid_stb_quiet", 32'(s_bus.stb), 32'd0);
        step();
        check("rst_after_state", 32'(dbg_state), 32'd0);
        check("rst_after_gnt", 32'(gnt), 32'h0);
        check("rst_after_s_stb", 32'(s_bus.stb), 32'd0);
        rst = 1'b0;
        set_m(1, 1'b0, 1'b0, 1'b0, '0, 32'd0, 4'b0000);
        step();
        step();

        check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
        check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
